// File: rtl/decoder_arbiter.sv
`timescale 1ns/1ps
// Purpose: 4-way round-robin arbiter whose one-hot grant matches a 2-to-4 decoder of sel, with bounded hold and a dead GAP cycle.
// Latency: one cycle from request to registered grant/sel/busy; at least one dead cycle between two grants.
// Backpressure: none; req is a level request, and the winner keeps the grant while requesting, up to MAX_HOLD cycles.
// Build option: define ARB_GRANT_INV_EN for an active-low grant (inactive value 4'b1111); sel, busy and timing are unchanged.
module decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Last hold count value a winner may reach before it is forced off.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

`ifdef ARB_GRANT_INV_EN
    localparam logic [3:0] GRANT_OFF = 4'b1111;
`else
    localparam logic [3:0] GRANT_OFF = 4'b0000;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;
    logic       w_found;
    logic [1:0] w_win;
    logic [1:0] w_idx;

    // Decoder pattern for a winner index, in the selected grant polarity.
    function automatic logic [3:0] f_decode(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
`ifdef ARB_GRANT_INV_EN
        return ~onehot;
`else
        return onehot;
`endif
    endfunction

    // Round-robin search: scan from ptr+3 down to ptr so the lowest offset from ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next state and next registered outputs; sel only changes on a new grant.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_hold_nxt  = r_hold;
        w_busy_nxt  = 1'b0;
        w_grant_nxt = GRANT_OFF;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_win;
                    w_ptr_nxt   = w_win + 2'd1;
                    w_hold_nxt  = 8'd0;
                    w_busy_nxt  = 1'b1;
                    w_grant_nxt = f_decode(w_win);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[r_sel] || (r_hold == HOLD_LAST)) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_hold_nxt  = r_hold + 8'd1;
                    w_busy_nxt  = 1'b1;
                    w_grant_nxt = f_decode(r_sel);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any state, including an active grant.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_hold  <= 8'd0;
            r_busy  <= 1'b0;
            r_grant <= GRANT_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_hold  <= w_hold_nxt;
            r_busy  <= w_busy_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign busy  = r_busy;

endmodule

// File: tb/tb_decoder_arbiter.sv
`timescale 1ns/1ps
// Purpose: directed and random checks of decoder_arbiter grant order, hold limit, gap cycle, reset and fairness.
// Latency: expected outputs are queued when a request pattern is driven and compared one clock edge later.
// Backpressure: not applicable; the bench drives one req pattern per cycle.
module tb_decoder_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int LIMIT    = 3 * (MAX_HOLD + 1);

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] req       = 4'b0000;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    always #5 sys_clk = ~sys_clk;

    decoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .busy     (busy)
    );

    // Grant pattern required for a given busy/sel pair in this build's polarity.
    function automatic logic [3:0] exp_grant(input logic b, input logic [1:0] s);
        logic [3:0] g;
        g = b ? (4'b0001 << s) : 4'b0000;
`ifdef ARB_GRANT_INV_EN
        g = ~g;
`endif
        return g;
    endfunction

    function automatic logic is_granted(input logic [3:0] g, input int i);
`ifdef ARB_GRANT_INV_EN
        return !g[i];
`else
        return g[i];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of req, queue the expected registered outputs, compare after the edge.
    task automatic step(input logic [3:0] r, input logic eb, input logic [1:0] es, input string tag);
        exp_t e;
        req     = r;
        e.grant = exp_grant(eb, es);
        e.sel   = es;
        e.busy  = eb;
        e.tag   = tag;
        sb_q.push_back(e);
        @(posedge sys_clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, "_grant"}, 32'(grant), 32'(e.grant));
        check({e.tag, "_sel"},   32'(sel),   32'(e.sel));
        check({e.tag, "_busy"},  32'(busy),  32'(e.busy));
    endtask

    initial begin
        logic [3:0] r;
        int         waitc [4];
        logic       b;

        // Reset state, including with requests present during reset.
        sys_rst_n = 1'b0;
        step(4'b0000, 1'b0, 2'd0, "rst0");
        step(4'b1111, 1'b0, 2'd0, "rst_req");
        sys_rst_n = 1'b1;

        // All requesting: 0,1,2,3,0, each 16 cycles, one gap cycle between.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < MAX_HOLD; c++) step(4'b1111, 1'b1, 2'(k), "rr");
            step(4'b1111, 1'b0, 2'(k), "rr_gap");
        end
        for (int c = 0; c < MAX_HOLD; c++) step(4'b1111, 1'b1, 2'd0, "rr_wrap");
        step(4'b0000, 1'b0, 2'd0, "rr_end_gap");
        step(4'b0000, 1'b0, 2'd0, "rr_idle");

        // Short request from requester 2: 3 grant cycles, gap, idle.
        for (int c = 0; c < 3; c++) step(4'b0100, 1'b1, 2'd2, "single");
        step(4'b0000, 1'b0, 2'd2, "single_gap");
        step(4'b0000, 1'b0, 2'd2, "single_idle");

        // Lone requester 3 held: 16, gap, 16, gap, 8, released on the drop.
        for (int c = 0; c < 42; c++) begin
            b = !(c == 16 || c == 33);
            step(4'b1000, b, 2'd3, "hold");
        end
        step(4'b0000, 1'b0, 2'd3, "hold_drop");
        step(4'b0000, 1'b0, 2'd3, "hold_idle");

        // Reset in the 5th cycle of a grant to 2 drops it immediately; requester 1 then wins.
        for (int c = 0; c < 5; c++) step(4'b0100, 1'b1, 2'd2, "rst_mid");
        sys_rst_n = 1'b0;
        step(4'b0110, 1'b0, 2'd0, "rst_mid_drop");
        sys_rst_n = 1'b1;
        step(4'b0110, 1'b1, 2'd1, "post_rst");
        step(4'b1011, 1'b1, 2'd1, "ignore_others");
        step(4'b0100, 1'b0, 2'd1, "post_rst_gap");
        step(4'b0100, 1'b1, 2'd2, "post_rst_next");
        step(4'b0000, 1'b0, 2'd2, "post_rst_end");
        step(4'b0000, 1'b0, 2'd2, "post_rst_idle");

        // Random slowly-changing requests: decode invariant and bounded wait every cycle.
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r = req;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 15) == 0) r[i] = ~r[i];
            req = r;
            @(posedge sys_clk);
            #1;
            check("rand_decode", 32'(grant), 32'(exp_grant(busy, sel)));
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !is_granted(grant, i)) waitc[i]++;
                else waitc[i] = 0;
                n_checks++;
                assert (waitc[i] <= LIMIT) else begin
                    n_fail++;
                    $error("FAIL rand_wait%0d: observed %0d cycles, required at most %0d", i, waitc[i], LIMIT);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
